// File: rtl/conv_mem_pkg.sv
// rtl/conv_mem_pkg.sv - shared state type, width helper and layer defaults for conv output write sequencing
package conv_mem_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} conv_wr_state_t;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CONV1_IMG_W          = 8;
  localparam int CONV1_IMG_H          = 8;
  localparam int CONV1_NUM_CH         = 3;
  localparam int CONV1_CYCLES_PER_PIX = 25;
  localparam int CONV1_START_DELAY    = 1;

  localparam int CONV2_IMG_W          = 4;
  localparam int CONV2_IMG_H          = 4;
  localparam int CONV2_NUM_CH         = 8;
  localparam int CONV2_CYCLES_PER_PIX = 27;
  localparam int CONV2_START_DELAY    = 2;

endpackage

// File: rtl/conv_mem_write_gen_wrap_counter.sv
// rtl/conv_mem_write_gen_wrap_counter.sv - modulo-MAX counter with synchronous clear and terminal-count flag
module wrap_counter
  import conv_mem_pkg::*;
#(
  parameter  int MAX = 2,
  localparam int W   = clog2_min1(MAX)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/conv_mem_write_gen.sv
// rtl/conv_mem_write_gen.sv - per-layer output RAM write-address sequencer: channel x pixel walk with start/stall/clear/done
module conv_mem_write_gen
  import conv_mem_pkg::*;
#(
  parameter  int IMG_W          = CONV1_IMG_W,
  parameter  int IMG_H          = CONV1_IMG_H,
  parameter  int NUM_CH         = CONV1_NUM_CH,
  parameter  int CYCLES_PER_PIX = CONV1_CYCLES_PER_PIX,
  parameter  int START_DELAY    = CONV1_START_DELAY,
  localparam int NUM_PIX        = IMG_W * IMG_H,
  localparam int PIX_W          = clog2_min1(NUM_PIX),
  localparam int CH_W           = clog2_min1(NUM_CH),
  localparam int LIN_W          = clog2_min1(NUM_PIX * NUM_CH),
  localparam int MAC_W          = clog2_min1(CYCLES_PER_PIX)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stall,
  input  logic             i_clear,
  output logic             o_busy,
  output logic             o_wr_en,
  output logic [PIX_W-1:0] o_pix_addr,
  output logic [CH_W-1:0]  o_ch,
  output logic [LIN_W-1:0] o_lin_addr,
  output logic [MAC_W-1:0] o_mac_cnt,
  output logic             o_done
);

  conv_wr_state_t r_state;
  conv_wr_state_t w_next_state;
  logic             r_done;
  logic [LIN_W-1:0] r_lin_addr;

  logic w_accept, w_clr, w_run_go, w_wr_en, w_final;
  logic w_delay_last, w_mac_last, w_pix_last, w_ch_last;
  logic [MAC_W-1:0] w_mac_cnt;
  logic [PIX_W-1:0] w_pix_addr;
  logic [CH_W-1:0]  w_ch;

  assign w_accept = i_start && !i_clear && (r_state == IDLE || r_state == DONE);
  assign w_clr    = i_clear || w_accept;
  assign w_run_go = (r_state == RUN) && !i_stall;
  assign w_wr_en  = w_run_go && w_mac_last;
  assign w_final  = w_wr_en && w_pix_last && w_ch_last;

  generate
    if (START_DELAY > 0) begin : g_delay
      logic [clog2_min1(START_DELAY)-1:0] w_delay_cnt_unused;
      wrap_counter #(.MAX(START_DELAY)) u_delay_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .i_inc  ((r_state == DELAY) && !i_stall),
        .o_cnt  (w_delay_cnt_unused),
        .o_last (w_delay_last)
      );
    end else begin : g_no_delay
      assign w_delay_last = 1'b1;
    end
  endgenerate

  wrap_counter #(.MAX(CYCLES_PER_PIX)) u_mac_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_inc  (w_run_go),
    .o_cnt  (w_mac_cnt),
    .o_last (w_mac_last)
  );

  // The final write leaves pixel/channel parked on the last address for DONE.
  wrap_counter #(.MAX(NUM_PIX)) u_pix_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_inc  (w_wr_en && !w_final),
    .o_cnt  (w_pix_addr),
    .o_last (w_pix_last)
  );

  wrap_counter #(.MAX(NUM_CH)) u_ch_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_inc  (w_wr_en && w_pix_last && !w_final),
    .o_cnt  (w_ch),
    .o_last (w_ch_last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lin_addr <= '0;
    end else if (w_clr) begin
      r_lin_addr <= '0;
    end else if (w_wr_en && !w_final) begin
      r_lin_addr <= r_lin_addr + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (w_next_state == DONE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_clear) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (i_start) w_next_state = (START_DELAY == 0) ? RUN : DELAY;
        DELAY:      if (!i_stall && w_delay_last) w_next_state = RUN;
        RUN:        if (w_final) w_next_state = DONE;
        default:    w_next_state = IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state == DELAY) || (r_state == RUN);
  assign o_wr_en    = w_wr_en;
  assign o_pix_addr = w_pix_addr;
  assign o_ch       = w_ch;
  assign o_lin_addr = r_lin_addr;
  assign o_mac_cnt  = w_mac_cnt;
  assign o_done     = r_done;

endmodule

// File: tb/tb_conv_mem_write_gen.sv
// tb/tb_conv_mem_write_gen.sv - self-checking bench for conv_mem_write_gen (default layer and a 2x2 single-cycle layer)
module tb_conv_mem_write_gen;

  localparam int NPIX = 64;
  localparam int NCH  = 3;
  localparam int C    = 25;
  localparam int D    = 1;
  localparam int NTOT = NPIX * NCH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stall, clear;
  logic       busy, wr_en, done;
  logic [5:0] pix;
  logic [1:0] ch;
  logic [7:0] lin;
  logic [4:0] mac;

  logic       b_start, b_stall, b_clear;
  logic       b_busy, b_wr_en, b_done;
  logic [1:0] b_pix;
  logic [0:0] b_ch;
  logic [1:0] b_lin;
  logic [0:0] b_mac;

  conv_mem_write_gen dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stall(stall), .i_clear(clear),
    .o_busy(busy), .o_wr_en(wr_en), .o_pix_addr(pix), .o_ch(ch),
    .o_lin_addr(lin), .o_mac_cnt(mac), .o_done(done)
  );

  conv_mem_write_gen #(
    .IMG_W(2), .IMG_H(2), .NUM_CH(1), .CYCLES_PER_PIX(1), .START_DELAY(0)
  ) dut_small (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_stall(b_stall), .i_clear(b_clear),
    .o_busy(b_busy), .o_wr_en(b_wr_en), .o_pix_addr(b_pix), .o_ch(b_ch),
    .o_lin_addr(b_lin), .o_mac_cnt(b_mac), .o_done(b_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model: progress is the count of unstalled busy cycles since the accepted start.
  bit m_active, m_done;
  int m_t;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_done = 0; m_t = 0;
    end else if (clear) begin
      m_active = 0; m_done = 0; m_t = 0;
    end else if (!m_active && start) begin
      m_active = 1; m_done = 0; m_t = 0;
    end else if (m_active && !stall) begin
      m_t++;
      if (m_t == D + NTOT * C) begin
        m_active = 0; m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin : cmp
      int e_wr, e_pix, e_ch, e_lin, e_mac, k, u;
      e_wr = 0; e_pix = 0; e_ch = 0; e_lin = 0; e_mac = 0;
      if (m_done) begin
        e_lin = NTOT - 1; e_pix = (NTOT - 1) % NPIX; e_ch = NCH - 1;
      end else if (m_active && m_t >= D) begin
        u = m_t - D; k = u / C;
        e_mac = u % C; e_lin = k; e_pix = k % NPIX; e_ch = k / NPIX;
        e_wr  = (e_mac == C - 1 && !stall) ? 1 : 0;
      end
      chk("cyc_busy", busy, m_active);
      chk("cyc_done", done, m_done);
      chk("cyc_wr_en", wr_en, e_wr);
      chk("cyc_pix", pix, e_pix);
      chk("cyc_ch", ch, e_ch);
      chk("cyc_lin", lin, e_lin);
      chk("cyc_mac", mac, e_mac);
    end
  end

  task automatic pulse_start(output int s);
    @(negedge clk); start = 1;
    @(posedge clk); #1 s = cyc;
    @(negedge clk); start = 0;
  endtask

  task automatic run_a(input int s, input int budget, input int stall_pix, input bit pulses,
                       output int first, output int nwr, output int done_at, output int pix5);
    int  left;
    bit  stalled;
    left = 0; stalled = 0;
    first = -1; nwr = 0; done_at = -1; pix5 = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      start = pulses && (i == 100 || i == 2000 || i == 4000);
      if (stall_pix >= 0 && !stalled && busy && ch == 0 && int'(pix) == stall_pix && mac == C - 1) begin
        stall = 1; left = 10; stalled = 1;
      end else if (left > 0) begin
        left--;
        if (left == 0) stall = 0;
      end
      #1;
      if (wr_en) begin
        nwr++;
        if (first < 0) first = cyc + 1 - s;
        if (lin == 5) pix5++;
      end
      if (done) begin
        done_at = cyc - s;
        break;
      end
    end
    start = 0; stall = 0;
  endtask

  task automatic wait_lin(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (lin == target) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int s, first, nwr, done_at, p5, nq;
    bit ok;
    rst = 1; start = 0; stall = 0; clear = 0;
    b_start = 0; b_stall = 0; b_clear = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_lin", lin, 0);
    chk("rst_mac", mac, 0);
    chk("rst_small_done", b_done, 0);
    @(negedge clk); rst = 0;

    pulse_start(s);
    chk("start_busy", busy, 1);
    run_a(s, 6000, -1, 1, first, nwr, done_at, p5);
    chk("run1_first_wr", first, 26);
    chk("run1_writes", nwr, 192);
    chk("run1_done_at", done_at, 4801);
    chk("run1_hold_lin", lin, 191);
    chk("run1_hold_pix", pix, 63);
    chk("run1_hold_ch", ch, 2);

    pulse_start(s);
    chk("restart_done_drop", done, 0);
    chk("restart_busy", busy, 1);
    run_a(s, 6000, -1, 0, first, nwr, done_at, p5);
    chk("run2_first_wr", first, 26);
    chk("run2_writes", nwr, 192);
    chk("run2_done_at", done_at, 4801);

    pulse_start(s);
    run_a(s, 6000, 5, 0, first, nwr, done_at, p5);
    chk("stall_first_wr", first, 26);
    chk("stall_writes", nwr, 192);
    chk("stall_done_at", done_at, 4811);
    chk("stall_pix5_writes", p5, 1);

    pulse_start(s);
    wait_lin(10, 1000, ok);
    chk("clear_reach_pix10", ok, 1);
    @(negedge clk); clear = 1;
    @(negedge clk); clear = 0;
    #1;
    chk("clear_busy", busy, 0);
    chk("clear_lin", lin, 0);
    nq = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (wr_en) nq++;
    end
    chk("clear_no_writes", nq, 0);
    @(negedge clk); start = 1; clear = 1;
    @(negedge clk); start = 0; clear = 0;
    #1;
    chk("clear_start_busy", busy, 0);
    chk("clear_start_done", done, 0);

    pulse_start(s);
    wait_lin(104, 4000, ok);
    chk("rstmid_reach", ok, 1);
    chk("rstmid_ch", ch, 1);
    chk("rstmid_pix", pix, 40);
    @(negedge clk); rst = 1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_lin", lin, 0);
    chk("rstmid_pix0", pix, 0);
    chk("rstmid_ch0", ch, 0);
    chk("rstmid_mac", mac, 0);
    @(negedge clk); rst = 0;
    pulse_start(s);
    run_a(s, 6000, -1, 0, first, nwr, done_at, p5);
    chk("run3_first_wr", first, 26);
    chk("run3_writes", nwr, 192);
    chk("run3_done_at", done_at, 4801);

    @(negedge clk); b_start = 1;
    @(posedge clk);
    @(negedge clk); b_start = 0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("small_wr_en", b_wr_en, 1);
      chk("small_lin", b_lin, j);
      chk("small_pix", b_pix, j);
      chk("small_done_early", b_done, 0);
      @(negedge clk);
    end
    #1;
    chk("small_wr_end", b_wr_en, 0);
    chk("small_done", b_done, 1);
    chk("small_busy_end", b_busy, 0);
    chk("small_hold_lin", b_lin, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
